// File: rtl/mem_access_unit.sv
// mem_access_unit - load/store unit for the multicycle MIPS datapath.
//
// Sits between the control unit / ALUOut address path and a word-wide
// memory. Handles word, half-word and byte accesses; sub-word loads are sign-
// or zero-extended, sub-word stores are a read-modify-write of the addressed
// word. Misaligned or reserved-size requests complete immediately with a
// fault and never touch memory.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 request strobe, only sampled while idle
//   op_write              1 = store, 0 = load
//   size                  00 word, 01 half, 10 byte, 11 reserved (faults)
//   sign_ext              loads only: 1 = sign-extend, 0 = zero-extend
//   addr                  byte address
//   wdata                 right-aligned store data
//   busy                  high whenever an operation is in flight
//   done                  one-cycle completion pulse
//   misaligned            qualifies done: request faulted, no write happened
//   rdata                 extended load result, held until the next load
//   mem_addr              word-aligned memory address
//   mem_wr, mem_wdata     single-cycle memory write and merged store word
//   mem_rdata             memory read data
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned BIG_ENDIAN  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR,
    S_DONE,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;

  // Lane selection: big-endian mirrors the byte index (3 - addr[1:0]) and
  // swaps which half of the word a half-word address refers to.
  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        req_fault;

  always_comb begin
    byte_lane = (BIG_ENDIAN != 0) ? ~addr_q[1:0] : addr_q[1:0];
    half_hi   = (BIG_ENDIAN != 0) ? ~addr_q[1] : addr_q[1];

    lane_byte = '0;
    case (byte_lane)
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = '0;
    endcase
    lane_half = half_hi ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      SZ_BYTE: load_val = {{24{sext_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_val = {{16{sext_q & lane_half[15]}}, lane_half};
      default: load_val = mem_rdata;
    endcase

    // Read-modify-write: only the addressed lane takes store data.
    merged = mem_rdata;
    if (size_q == SZ_BYTE) begin
      case (byte_lane)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (half_hi) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    req_fault = 1'b0;
    case (size)
      SZ_WORD: req_fault = (addr[1:0] != 2'b00);
      SZ_HALF: req_fault = addr[0];
      SZ_BYTE: req_fault = 1'b0;
      default: req_fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    sext_d     = sext_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    busy       = 1'b1;
    done       = 1'b0;
    misaligned = 1'b0;
    mem_wr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata[15:0];
          size_d  = size;
          sext_d  = sign_ext;
          write_d = op_write;
          cnt_d   = CNT_W'(MEM_LATENCY);
          if (req_fault) begin
            state_d = S_FAULT;
          end else if (op_write && (size == SZ_WORD)) begin
            // Full-word stores skip the read; the word goes out unchanged.
            word_d  = wdata;
            state_d = S_WR;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (write_q) begin
            word_d  = merged;
            state_d = S_WR;
          end else begin
            word_d  = mem_rdata;
            rdata_d = load_val;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR: begin
        mem_wr  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        done       = 1'b1;
        misaligned = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = word_q;
  assign rdata     = rdata_q;

endmodule
